num_entry: RTL and testbench
============================

Name: num_entry

Overview:
- Push-button decimal number entry: the input-side counterpart of the signed-decimal display path.
- Accepts one decimal digit per strobe from the slide switches, plus sign, clear and enter strobes.
- Builds a signed 8-bit two's-complement value with range checking.
- Sits after the Synchroniser/Debounce/DetectFallingEdge chain and feeds the calculator datapath. The live entry value goes to the decimal display.

Parameters:
MAX_DIGITS, 3, maximum significant decimal digits accepted per entry (1..3)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
digit_in  input  4  BCD digit from switches, sampled only when digit_stb=1
digit_stb  input  1  single-cycle pulse: append digit_in
neg_stb  input  1  single-cycle pulse: toggle sign of current entry
clr_stb  input  1  single-cycle pulse: abort entry, return to IDLE
enter_stb  input  1  single-cycle pulse: commit current entry
entry  output  8  signed live value (neg ? -mag : mag), for display
entry_neg  output  1  current sign flag, so the display can show "-0"
ndigits  output  2  significant digits entered so far
result  output  8  signed last committed value, held until next commit
result_valid  output  1  single-cycle pulse on commit
err  output  1  sticky error, cleared by clr_stb or by a new entry's first digit
state  output  2  IDLE=0, ENTRY=1, DONE=2, ERR=3

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE; mag=0; entry_neg=0; ndigits=0; entry=0.
  - result=0; result_valid=0; err=0.
- All updates occur on the rising edge of clk.
- Outputs are registered or decoded directly from registers, so there is 1-cycle latency from strobe to output.
- Strobe priority when several are high in the same cycle: clr_stb > enter_stb > neg_stb > digit_stb. Only the highest-priority strobe acts; the others are dropped.
- Internal magnitude mag is 8 bits unsigned. The limit is 128 when entry_neg=1, otherwise 127.
- Digit accept:
  - Candidate = mag*10 + digit_in, computed in 12 bits.
  - Accepted only if all hold: digit_in<=9, candidate<=limit, and the digit count is within MAX_DIGITS.
  - A leading zero (mag=0, digit 0) is accepted but does not increment ndigits.
- Digit reject: mag, ndigits and sign are unchanged; err<=1; state<=ERR.
- States:
  - IDLE: entry=0.
    - digit_stb -> apply digit, go to ENTRY.
    - neg_stb -> entry_neg<=1, go to ENTRY.
    - enter_stb -> commit 0.
    - clr_stb -> stay.
  - ENTRY:
    - digit_stb / neg_stb update the entry.
    - enter_stb -> result<=entry; result_valid=1 for one cycle; go to DONE.
    - clr_stb -> mag=0, neg=0, ndigits=0, go to IDLE.
  - DONE: entry keeps showing the committed value.
    - digit_stb -> clear mag/neg/ndigits, apply the digit as the first digit of a new entry, go to ENTRY.
    - neg_stb -> negate the committed value in a fresh entry, go to ENTRY. The rule below applies.
    - enter_stb -> re-commit the same value, with a new result_valid pulse.
    - clr_stb -> go to IDLE.
  - ERR: entry holds the last legal value.
    - clr_stb -> go to IDLE with err cleared.
    - enter_stb -> commit the held legal value and go to DONE; err stays 1.
    - digit_stb / neg_stb are processed as in ENTRY. On success, go to ENTRY with err still 1.
- Sign toggle with mag=128 and entry_neg=1 is rejected (+128 is unrepresentable): err<=1, state<=ERR, value unchanged.
- entry_neg=1 with mag=0 shows "-0". Committing it yields result=0.
- err clears only on clr_stb or on the first accepted digit after DONE/IDLE.
- result_valid is never high for two consecutive cycles unless enter_stb is high on two consecutive cycles.
- Reset mid-entry: all registers return immediately (asynchronously) to reset values; any in-progress result_valid pulse is cut.

Test Plan:
- Reset released; digits 1,2,7 then enter -> entry 1,12,127; result=127 (8'h7F); one-cycle result_valid; state DONE.
- neg, digits 1,2,8, enter -> entry_neg=1, entry=-128 (8'h80), result=8'h80; then neg_stb -> err=1, state ERR, entry stays 8'h80.
- Digits 1,2, then 8 (128 > 127) -> digit rejected, entry=12, err=1; clr_stb -> entry 0, err 0, state IDLE.
- digit_in=4'hA with strobe, and a fourth digit after "0,0,1,2,3" (leading zeros accepted, ndigits=3) -> both rejected; value 123 retained, err=1.
- Same-cycle clr_stb+enter_stb in ENTRY -> clear wins, no result_valid. Same-cycle enter_stb+digit_stb -> commit only; the digit is ignored.
- rst_n pulled low asynchronously mid-entry (entry=-45) -> all outputs 0 before the next clk edge; the following strobes behave as from IDLE.

Source files
------------

// File: rtl/num_entry.sv
// Push-button signed decimal entry: digit/sign/clear/enter strobes build an 8-bit two's-complement value.
// Latency: 1 cycle from strobe to entry/result/result_valid; all outputs come from registers.
// Backpressure: none; strobes are single-cycle pulses, and only the highest-priority strobe acts.
module num_entry #(
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_in,
    input  logic       digit_stb,
    input  logic       neg_stb,
    input  logic       clr_stb,
    input  logic       enter_stb,
    output logic [7:0] entry,
    output logic       entry_neg,
    output logic [1:0] ndigits,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [2:0] MAXD = 3'(MAX_DIGITS);

    state_t     state_q, state_d;
    logic [7:0] mag_q, mag_d;
    logic       neg_q, neg_d;
    logic [1:0] ndig_q, ndig_d;
    logic [7:0] result_q, result_d;
    logic       rv_q, rv_d;
    logic       err_q, err_d;

    logic [7:0]  cur_val;
    logic [7:0]  base_mag;
    logic        base_neg;
    logic [1:0]  base_ndig;
    logic [11:0] cand;
    logic [11:0] limit;
    logic        lead0;
    logic        dig_ok;

    assign cur_val = neg_q ? (~mag_q + 8'd1) : mag_q;

    // A digit after a commit starts a fresh entry rather than extending the committed value.
    always_comb begin
        base_mag  = mag_q;
        base_neg  = neg_q;
        base_ndig = ndig_q;
        if (state_q == S_DONE) begin
            base_mag  = 8'd0;
            base_neg  = 1'b0;
            base_ndig = 2'd0;
        end
        cand   = (12'(base_mag) * 12'd10) + 12'(digit_in);
        limit  = base_neg ? 12'd128 : 12'd127;
        lead0  = (base_mag == 8'd0) && (digit_in == 4'd0);
        dig_ok = (digit_in <= 4'd9) && (cand <= limit)
                 && (lead0 || ({1'b0, base_ndig} < MAXD));
    end

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        ndig_d   = ndig_q;
        result_d = result_q;
        rv_d     = 1'b0;
        err_d    = err_q;

        if (clr_stb) begin
            state_d = S_IDLE;
            mag_d   = 8'd0;
            neg_d   = 1'b0;
            ndig_d  = 2'd0;
            err_d   = 1'b0;
        end else if (enter_stb) begin
            result_d = cur_val;
            rv_d     = 1'b1;
            state_d  = S_DONE;
        end else if (neg_stb) begin
            // -128 has no positive counterpart in 8 bits.
            if (neg_q && (mag_q == 8'd128)) begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end else begin
                neg_d   = ~neg_q;
                state_d = S_ENTRY;
            end
        end else if (digit_stb) begin
            if (dig_ok) begin
                mag_d   = cand[7:0];
                neg_d   = base_neg;
                ndig_d  = lead0 ? base_ndig : base_ndig + 2'd1;
                state_d = S_ENTRY;
                if ((state_q == S_IDLE) || (state_q == S_DONE))
                    err_d = 1'b0;
            end else begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mag_q    <= 8'd0;
            neg_q    <= 1'b0;
            ndig_q   <= 2'd0;
            result_q <= 8'd0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            neg_q    <= neg_d;
            ndig_q   <= ndig_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
        end
    end

    assign entry        = cur_val;
    assign entry_neg    = neg_q;
    assign ndigits      = ndig_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign err          = err_q;
    assign state        = state_q;

endmodule

// File: tb/tb_num_entry.sv
// Directed bench for num_entry: committed results go through a scoreboard queue, live outputs are checked inline.
module tb_num_entry;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       digit_stb = 1'b0;
    logic       neg_stb = 1'b0;
    logic       clr_stb = 1'b0;
    logic       enter_stb = 1'b0;
    logic [7:0] entry;
    logic       entry_neg;
    logic [1:0] ndigits;
    logic [7:0] result;
    logic       result_valid;
    logic       err;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_res;

    num_entry #(.MAX_DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .digit_in(digit_in), .digit_stb(digit_stb), .neg_stb(neg_stb),
        .clr_stb(clr_stb), .enter_stb(enter_stb),
        .entry(entry), .entry_neg(entry_neg), .ndigits(ndigits),
        .result(result), .result_valid(result_valid), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe cycle, then one idle cycle; returns 1 time unit after the updating edge.
    task automatic strobe(input logic [3:0] d, input logic dg, input logic ng,
                          input logic cl, input logic en);
        @(posedge clk);
        #1;
        digit_in = d; digit_stb = dg; neg_stb = ng; clr_stb = cl; enter_stb = en;
        @(posedge clk);
        #1;
        digit_stb = 1'b0; neg_stb = 1'b0; clr_stb = 1'b0; enter_stb = 1'b0;
    endtask

    task automatic dig(input logic [3:0] d);
        strobe(d, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter(input logic [7:0] expect_res);
        sb.push_back(expect_res);
        strobe(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL rv_unexpected: observed pulse with result %0h expected no pulse", result);
            end else begin
                exp_res = sb.pop_front();
                assert (result === exp_res) else begin
                    errors++;
                    $error("FAIL sb_result: observed %0h expected %0h", result, exp_res);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_entry", 32'(entry), 32'h00);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_result", 32'(result), 32'h00);
        chk("rst_misc", {28'd0, entry_neg, ndigits, err}, 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1,2,7 -> +127 commit
        dig(4'd1); chk("e1", 32'(entry), 32'd1);
        dig(4'd2); chk("e12", 32'(entry), 32'd12);
        dig(4'd7); chk("e127", 32'(entry), 32'h7F); chk("nd3", 32'(ndigits), 32'd3);
        enter(8'h7F);
        chk("c127_state", 32'(state), 32'd2);
        chk("c127_rv", 32'(result_valid), 32'd1);
        chk("c127_res", 32'(result), 32'h7F);
        @(posedge clk); #1;
        chk("c127_rv_low", 32'(result_valid), 32'd0);

        // -128 commit, then negate it -> rejected
        strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        strobe(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("neg_flag", 32'(entry_neg), 32'd1);
        chk("neg_state", 32'(state), 32'd1);
        dig(4'd1); dig(4'd2); dig(4'd8);
        chk("em128", 32'(entry), 32'h80);
        enter(8'h80);
        chk("cm128_res", 32'(result), 32'h80);
        strobe(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("negm128_err", 32'(err), 32'd1);
        chk("negm128_state", 32'(state), 32'd3);
        chk("negm128_entry", 32'(entry), 32'h80);

        // +128 out of range
        strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_err", 32'(err), 32'd0);
        dig(4'd1); dig(4'd2); dig(4'd8);
        chk("p128_entry", 32'(entry), 32'd12);
        chk("p128_err", 32'(err), 32'd1);
        chk("p128_state", 32'(state), 32'd3);
        strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr2_entry", 32'(entry), 32'd0);
        chk("clr2_err", 32'(err), 32'd0);
        chk("clr2_state", 32'(state), 32'd0);

        // leading zeros, non-BCD digit, fourth digit
        dig(4'd0); dig(4'd0);
        chk("lead0_nd", 32'(ndigits), 32'd0);
        chk("lead0_state", 32'(state), 32'd1);
        dig(4'd1); dig(4'd2); dig(4'd3);
        chk("e123", 32'(entry), 32'd123);
        chk("e123_nd", 32'(ndigits), 32'd3);
        dig(4'hA);
        chk("hexA_entry", 32'(entry), 32'd123);
        chk("hexA_err", 32'(err), 32'd1);
        dig(4'd0);
        chk("d4_entry", 32'(entry), 32'd123);
        chk("d4_nd", 32'(ndigits), 32'd3);
        enter(8'd123);
        chk("errcommit_state", 32'(state), 32'd2);
        chk("errcommit_err", 32'(err), 32'd1);
        dig(4'd5);
        chk("newdig_entry", 32'(entry), 32'd5);
        chk("newdig_err", 32'(err), 32'd0);
        chk("newdig_nd", 32'(ndigits), 32'd1);

        // priority: clr beats enter; enter beats digit
        strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clrenter_rv", 32'(result_valid), 32'd0);
        chk("clrenter_state", 32'(state), 32'd0);
        dig(4'd4); dig(4'd2);
        sb.push_back(8'd42);
        strobe(4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("entdig_entry", 32'(entry), 32'd42);
        chk("entdig_state", 32'(state), 32'd2);
        enter(8'd42);
        chk("recommit_rv", 32'(result_valid), 32'd1);
        strobe(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("done_neg_entry", 32'(entry), 32'hD6);
        chk("done_neg_state", 32'(state), 32'd1);

        // -0 commits as 0
        strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        strobe(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("m0_entry", 32'(entry), 32'd0);
        chk("m0_neg", 32'(entry_neg), 32'd1);
        enter(8'd0);

        // async reset mid-entry at -45
        strobe(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        strobe(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        dig(4'd4); dig(4'd5);
        chk("em45", 32'(entry), 32'hD3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_entry", 32'(entry), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_misc", {27'd0, entry_neg, ndigits, err, result_valid}, 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dig(4'd3);
        chk("post_rst_entry", 32'(entry), 32'd3);
        chk("post_rst_state", 32'(state), 32'd1);
        enter(8'd3);

        repeat (3) @(posedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
